// File: rtl/calc_pkg.sv
// Shared types for the clocked switch/button calculator.
// Opcodes, controller states and button count.
package calc_pkg;

  localparam int NUM_BTN = 4;

  typedef enum logic [2:0] {
    OP_ADDSUB,
    OP_SORT,
    OP_MUL,
    OP_DIV,
    OP_SHOW
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DIV
  } state_e;

endpackage

// File: rtl/calc_div_seq.sv
// Iterative restoring divider, one quotient bit per clock.
// done_o is high in the final step; quot_o/rem_o carry that step's result.
module calc_div_seq #(
  parameter int BITS = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [BITS-1:0] a_i,
  input  logic [BITS-1:0] b_i,
  output logic            done_o,
  output logic [BITS-1:0] quot_o,
  output logic [BITS-1:0] rem_o
);

  localparam int CW = (BITS > 1) ? $clog2(BITS) : 1;

  logic            run_q;
  logic [CW-1:0]   cnt_q;
  logic [BITS-1:0] q_q, q_d;
  logic [BITS-1:0] r_q, r_d;
  logic [BITS-1:0] d_q;

  logic [2*BITS-1:0] rem_w;
  logic [2*BITS-1:0] dsh_w;
  logic              take_w;

  // Divisor shifted at double width so it can never wrap.
  assign rem_w  = {{BITS{1'b0}}, r_q};
  assign dsh_w  = {{BITS{1'b0}}, d_q} << cnt_q;
  assign take_w = rem_w >= dsh_w;

  always_comb begin
    q_d = q_q;
    r_d = r_q;
    if (take_w) begin
      q_d[cnt_q] = 1'b1;
      r_d = r_q - dsh_w[BITS-1:0];
    end
  end

  assign done_o = run_q && (cnt_q == '0);
  assign quot_o = q_d;
  assign rem_o  = r_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      q_q   <= '0;
      r_q   <= '0;
      d_q   <= '0;
    end else if (start_i) begin
      run_q <= 1'b1;
      cnt_q <= CW'(BITS - 1);
      q_q   <= '0;
      r_q   <= a_i;
      d_q   <= b_i;
    end else if (run_q) begin
      q_q   <= q_d;
      r_q   <= r_d;
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == '0) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/calc_ctrl.sv
// Clocked calculator controller: button sync, dispatch, held LED result.
// Define CALC_DIVZERO_EN to flag divide-by-zero on err instead of dividing.
module calc_ctrl
  import calc_pkg::*;
#(
  parameter int BITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2*BITS-1:0]   sw,
  input  logic [NUM_BTN-1:0]  btn,
  output logic [2*BITS-1:0]   led,
  output logic                busy,
  output logic                err
);

`ifdef CALC_DIVZERO_EN
  localparam bit DZ_EN = 1'b1;
`else
  localparam bit DZ_EN = 1'b0;
`endif

  logic [NUM_BTN-1:0] s1_q, s2_q, s3_q;
  logic [NUM_BTN-1:0] rise_w;
  logic               press_w, multi_w, dz_w;
  op_e                op_w;

  state_e state_q, state_d;
  op_e    op_q, op_d;
  logic [BITS-1:0]   a_q, a_d, b_q, b_d;
  logic [2*BITS-1:0] led_q, led_d;
  logic              err_q, err_d;

  logic              div_start;
  logic              div_done;
  logic [BITS-1:0]   div_q, div_r;

  assign rise_w  = s2_q & ~s3_q;
  assign press_w = |rise_w;
  assign multi_w = |(rise_w & (rise_w - NUM_BTN'(1)));
  assign dz_w    = DZ_EN && (sw[BITS-1:0] == '0);

  always_comb begin
    op_w = OP_SHOW;
    if (press_w && !multi_w) begin
      unique case (1'b1)
        rise_w[0]: op_w = OP_ADDSUB;
        rise_w[1]: op_w = OP_SORT;
        rise_w[2]: op_w = OP_MUL;
        rise_w[3]: op_w = OP_DIV;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    led_d     = led_q;
    err_d     = err_q;
    div_start = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (press_w) begin
          a_d   = sw[2*BITS-1:BITS];
          b_d   = sw[BITS-1:0];
          op_d  = op_w;
          err_d = 1'b0;
          if (op_w == OP_DIV && !dz_w) begin
            state_d   = DIV;
            div_start = 1'b1;
          end else begin
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        state_d = IDLE;
        unique case (op_q)
          OP_ADDSUB: led_d = {a_q + b_q, a_q - b_q};
          OP_SORT:   led_d = (a_q < b_q) ? {a_q, b_q} : {b_q, a_q};
          OP_MUL:    led_d = {{BITS{1'b0}}, a_q} * {{BITS{1'b0}}, b_q};
          OP_SHOW:   led_d = {a_q, b_q};
          // Only a zero-divisor DIV reaches here.
          OP_DIV: begin
            led_d = '1;
            err_d = DZ_EN;
          end
          default:   led_d = led_q;
        endcase
      end
      DIV: begin
        if (div_done) begin
          state_d = IDLE;
          led_d   = {div_q, div_r};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= '0;
      s2_q    <= '0;
      s3_q    <= '0;
      state_q <= IDLE;
      op_q    <= OP_ADDSUB;
      a_q     <= '0;
      b_q     <= '0;
      led_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      s1_q    <= btn;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      led_q   <= led_d;
      err_q   <= err_d;
    end
  end

  calc_div_seq #(.BITS(BITS)) u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (div_start),
    .a_i     (sw[2*BITS-1:BITS]),
    .b_i     (sw[BITS-1:0]),
    .done_o  (div_done),
    .quot_o  (div_q),
    .rem_o   (div_r)
  );

  assign led  = led_q;
  assign busy = (state_q != IDLE);
  assign err  = err_q;

endmodule

// File: doc/calc_ctrl.md
# calc_ctrl

Sequential controller for the switch/button calculator. It synchronises and edge-detects the four push buttons, latches the operands from the switches, and dispatches one operation per press. Add/subtract, sort and multiply finish in one cycle. Division runs on a shared iterative divider, one quotient bit per clock. The result is held on the LEDs until the next accepted press; it replaces the purely combinational calculator top on the clocked board build.

## Interface
- BITS, 4, operand width; `sw`/`led` are 2*BITS wide
- clk  in  1  system clock, rising-edge
- rst_n  in  1  asynchronous, active-low reset
- sw  in  2*BITS  operands: a = sw[2*BITS-1:BITS], b = sw[BITS-1:0]
- btn  in  4  raw push buttons, asynchronous to clk
- led  out  2*BITS  registered result
- busy  out  1  high while an operation is in flight; presses are ignored
- err  out  1  divide-by-zero flag; tied 0 unless CALC_DIVZERO_EN is defined

## Operation
- Buttons pass through a two-flop synchronizer (s1, s2) and a delay flop s3.
  - rise = s2 & ~s3, evaluated per bit.
- A press is accepted only in IDLE. Rises seen while busy are dropped, not queued.
- Opcode from the rise vector:
  - exactly 0001 -> ADDSUB
  - 0010 -> SORT
  - 0100 -> MUL
  - 1000 -> DIV
  - more than one bit set in the same cycle -> SHOW
- On acceptance, a and b are latched from sw. Later switch changes do not affect the operation in flight.
- ADDSUB: led = {a+b, a-b}, each field modulo 2^BITS.
- SORT: led = {min(a,b), max(a,b)}.
- MUL: led = a*b, the full 2*BITS-bit product.
- SHOW: led = {a, b}.
- DIV: led = {quotient, remainder}, using restoring division from MSB down.
  - Step i (BITS-1..0): if (R >> i) >= b, set q[i] = 1 and R = R - (b << i). R starts at a.
  - b << i is computed at 2*BITS width, so it cannot overflow.
- States:
  - IDLE -> EXEC on a non-DIV press
  - IDLE -> DIV on a DIV press
  - EXEC -> IDLE after 1 cycle
  - DIV -> IDLE after BITS cycles
- Reset, including mid-division: state IDLE, led 0, busy 0, err 0, synchronizer flops 0, divider registers 0. Any in-flight result is discarded.
- A button held through reset release registers as a press once s2 goes high.

## Timing
- btn rising at edge T0 gives rise high in the cycle after edge T0+2.
- Acceptance edge E latches the opcode and operands. busy goes high after E.
- Single-cycle ops: led updates and busy falls at edge E+1. Next press can be accepted at E+1.
- DIV: one quotient bit per edge from E+1 to E+BITS. led updates and busy falls at E+BITS; with BITS=4 that is the 4th edge after E.
- led holds its value in all other cycles. Releasing the buttons does not clear it.

## Configuration
- CALC_DIVZERO_EN defined:
  - DIV with b == 0 skips the DIV state.
  - At E+1: led = all ones, err = 1, busy falls.
  - err stays high until the next accepted press of any kind, which clears it at that press's acceptance edge.
- CALC_DIVZERO_EN undefined:
  - b == 0 runs the normal BITS-cycle division, giving quotient all ones and remainder a.
  - err is constant 0.

## Structure
- Package calc_pkg:
  - opcode enum: OP_ADDSUB, OP_SORT, OP_MUL, OP_DIV, OP_SHOW
  - state enum: IDLE, EXEC, DIV
  - constant NUM_BTN = 4
- One sub-module, calc_div_seq: iterative divider with start/done, BITS parameter, quotient/remainder registers and a step counter. calc_ctrl instantiates it.

## Test plan
- Reset, then press btn[0] with sw=8'h53 -> after sync latency plus 1 cycle, led=8'h82 and busy pulses for 1 cycle.
- Press btn[3] with sw=8'hD3 (13/3) -> busy high for exactly 4 cycles, then led=8'h41.
- Press btn[1] with sw=8'h92 -> led=8'h29. Press btn[2] with sw=8'hFF -> led=8'hE1.
- Press btn[3], then press btn[0] and change sw during the DIV state -> btn[0] is ignored and led shows the quotient/remainder of the originally latched operands.
- Press btn[3] with sw=8'h70:
  - with CALC_DIVZERO_EN -> led=8'hFF and err=1 after 1 cycle; a following btn[0] press clears err.
  - without it -> after 4 cycles led=8'hF7, err=0.
- Assert rst_n low during the DIV state -> led=0, busy=0 immediately. Press btn[1] and btn[2] together with sw=8'hA5 -> led=8'hA5.
